// File: rtl/uart_bus_arb.sv
// Round-robin arbiter sharing one uart register bus between NREQ requesters; one strobe per transfer.
// Optional macro UART_ARB_LOCK_EN adds req_lock so one requester can hold the bus for atomic read-modify-write.
module uart_bus_arb #(
    parameter int NREQ = 2,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wd,
`ifdef UART_ARB_LOCK_EN
    input  logic [NREQ-1:0]      req_lock,
`endif
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_rd,
    output logic [AW-1:0]        addr,
    output logic                 we,
    output logic                 re,
    output logic [DW-1:0]        wd,
    input  logic [DW-1:0]        rd,
    output logic [1:0]           dbg_state
);
    // Handshake: a requester holds req (with req_we/req_addr/req_wd) until it sees gnt; data is captured
    // on the gnt cycle's clock edge and rsp_valid pulses exactly two cycles later with rsp_rd qualified.
    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_w;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wd;
    logic [DW-1:0]   r_rsp_rd;
    logic [PW-1:0]   w_start;
    logic [PW-1:0]   w_scan_win;
    logic            w_scan_any;
    logic [PW-1:0]   w_win;
    logic            w_any;
    logic [NREQ-1:0] w_gnt;
    logic [NREQ-1:0] w_rsp;

    // NREQ need not be a power of two, so the wrap is explicit.
    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        if (p == PW'(NREQ - 1)) return '0;
        return p + PW'(1);
    endfunction

`ifdef UART_ARB_LOCK_EN
    logic r_lock;
    logic w_hold;
    assign w_hold  = r_lock & req[r_w];
    assign w_start = r_lock ? f_inc(r_w) : r_ptr;
    assign w_any   = w_hold | w_scan_any;
    assign w_win   = w_hold ? r_w : w_scan_win;
`else
    assign w_start = r_ptr;
    assign w_any   = w_scan_any;
    assign w_win   = w_scan_win;
`endif

    always_comb begin
        int idx;
        w_scan_any = 1'b0;
        w_scan_win = '0;
        idx        = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(w_start) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!w_scan_any && req[idx]) begin
                w_scan_any = 1'b1;
                w_scan_win = PW'(idx);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        w_gnt  = '0;
        w_rsp  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_next = S_ACCESS;
                    if (!rst) w_gnt[w_win] = 1'b1;
                end
            end
            S_ACCESS: w_next = S_RESP;
            S_RESP: begin
                w_next        = S_IDLE;
                w_rsp[r_w]    = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr    <= '0;
            r_w      <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wd     <= '0;
            r_rsp_rd <= '0;
`ifdef UART_ARB_LOCK_EN
            r_lock   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
`ifdef UART_ARB_LOCK_EN
                    // Owner dropped its request: release and resume rotation after it.
                    if (r_lock && !req[r_w]) begin
                        r_lock <= 1'b0;
                        r_ptr  <= f_inc(r_w);
                    end
`endif
                    if (w_any) begin
                        r_w    <= w_win;
                        r_we   <= req_we[w_win];
                        r_addr <= req_addr[int'(w_win)*AW +: AW];
                        r_wd   <= req_wd[int'(w_win)*DW +: DW];
`ifdef UART_ARB_LOCK_EN
                        r_lock <= req_lock[w_win];
`endif
                    end
                end
                S_ACCESS: r_rsp_rd <= r_we ? '0 : rd;
                S_RESP: begin
`ifdef UART_ARB_LOCK_EN
                    if (!r_lock) r_ptr <= f_inc(r_w);
`else
                    r_ptr <= f_inc(r_w);
`endif
                end
                default: ;
            endcase
        end
    end

    assign gnt       = w_gnt;
    assign rsp_valid = w_rsp;
    assign rsp_rd    = r_rsp_rd;
    assign addr      = r_addr;
    assign wd        = r_wd;
    assign we        = (r_state == S_ACCESS) &  r_we;
    assign re        = (r_state == S_ACCESS) & ~r_we;
    assign dbg_state = r_state;

endmodule
